// File: rtl/cu_pkg.sv
// Shared types and constants for the multicycle control-unit sequencer.
package cu_pkg;

  typedef enum logic [6:0] {
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    BRANCH = 7'b1100011,
    LW     = 7'b0000011,
    SW     = 7'b0100011,
    OP_IMM = 7'b0010011,
    OP_RG3 = 7'b0110011,
    CSR    = 7'b1110011
  } opcode_t;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WB    = 2'd2,
    ST_INTR  = 2'd3
  } cu_state_t;

  localparam logic [2:0] F3_MRET  = 3'b000;
  localparam logic [2:0] F3_CSRRW = 3'b001;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cu_fsm_irq_arb.sv
// Edge-triggered interrupt capture with lowest-index-first arbitration.
module irq_arb
  import cu_pkg::*;
#(
  parameter int  NUM_IRQ  = 4,
  localparam int IRQ_ID_W = id_width(NUM_IRQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic                ack_en,
  output logic                any_pend,
  output logic [IRQ_ID_W-1:0] sel,
  output logic [NUM_IRQ-1:0]  onehot
);

  logic [NUM_IRQ-1:0] r_irq_q;
  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] w_edge;
  logic [NUM_IRQ-1:0] w_ack;

  assign w_edge = irq_in & ~r_irq_q;
  assign w_ack  = ack_en ? onehot : '0;

  // A fresh edge on the channel being acknowledged keeps it pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_q <= '0;
      r_pend  <= '0;
    end else begin
      r_irq_q <= irq_in;
      r_pend  <= (r_pend & ~w_ack) | w_edge;
    end
  end

  assign any_pend = |r_pend;
  assign onehot   = r_pend & (~r_pend + NUM_IRQ'(1));

  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (r_pend[i]) sel = IRQ_ID_W'(i);
    end
  end

endmodule

// File: rtl/cu_fsm_irq.sv
// Multicycle fetch/execute/writeback sequencer with interrupt trap entry.
// Optional build macro CU_ILLEGAL_TRAP_EN: unknown opcodes trap and drive illegal_instr.
module cu_fsm_irq
  import cu_pkg::*;
#(
  parameter int  NUM_IRQ  = 4,
  localparam int IRQ_ID_W = id_width(NUM_IRQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          opcode,
  input  logic [2:0]          func3,
  input  logic                mem_ready1,
  input  logic                mem_ready2,
  input  logic                mie,
  input  logic [NUM_IRQ-1:0]  irq_in,
  output logic                pc_write,
  output logic                reg_write,
  output logic                mem_rden1,
  output logic                mem_rden2,
  output logic                mem_we2,
  output logic                csr_we,
  output logic                mret_exec,
  output logic                int_taken,
  output logic [NUM_IRQ-1:0]  irq_ack,
  output logic [IRQ_ID_W-1:0] irq_id
`ifdef CU_ILLEGAL_TRAP_EN
  ,
  output logic                illegal_instr
`endif
);

  cu_state_t           r_state;
  cu_state_t           w_state_next;
  logic                w_any_pend;
  logic [IRQ_ID_W-1:0] w_sel;
  logic [NUM_IRQ-1:0]  w_onehot;
  logic                w_known;
  logic                w_is_mret;
  logic                w_done;
  logic                w_irq_go;
  logic                w_illegal;
  logic                w_trap_illegal;
  logic                w_ack_en;

  assign w_known   = opcode inside {LUI, AUIPC, JAL, JALR, BRANCH, LW, SW, OP_IMM, OP_RG3, CSR};
  assign w_is_mret = (r_state == ST_EXEC) && (opcode == CSR) && (func3 == F3_MRET);
  assign w_done    = (r_state == ST_EXEC && opcode != SW) ? 1'b1 : mem_ready2;
  // MRET always returns to fetch so mie can be restored before the next trap.
  assign w_irq_go  = mie && w_any_pend && !w_is_mret;
  assign w_ack_en  = (r_state == ST_INTR) && !w_trap_illegal;

`ifdef CU_ILLEGAL_TRAP_EN
  logic r_illegal_trap;
  assign w_illegal      = (r_state == ST_EXEC) && !w_known;
  assign w_trap_illegal = r_illegal_trap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_illegal_trap <= 1'b0;
    else        r_illegal_trap <= w_illegal;
  end
`else
  assign w_illegal      = 1'b0;
  assign w_trap_illegal = 1'b0;
`endif

  irq_arb #(.NUM_IRQ(NUM_IRQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .irq_in  (irq_in),
    .ack_en  (w_ack_en),
    .any_pend(w_any_pend),
    .sel     (w_sel),
    .onehot  (w_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FETCH;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_FETCH: if (mem_ready1) w_state_next = ST_EXEC;
      ST_EXEC: begin
        if (w_illegal)           w_state_next = ST_INTR;
        else if (opcode == LW)   w_state_next = ST_WB;
        else if (w_done)         w_state_next = w_irq_go ? ST_INTR : ST_FETCH;
      end
      ST_WB:   if (w_done) w_state_next = w_irq_go ? ST_INTR : ST_FETCH;
      ST_INTR: w_state_next = ST_FETCH;
    endcase
  end

  always_comb begin
    pc_write  = 1'b0;
    reg_write = 1'b0;
    mem_rden1 = 1'b0;
    mem_rden2 = 1'b0;
    mem_we2   = 1'b0;
    csr_we    = 1'b0;
    mret_exec = 1'b0;
    int_taken = 1'b0;
    irq_ack   = '0;
    irq_id    = '0;
`ifdef CU_ILLEGAL_TRAP_EN
    illegal_instr = 1'b0;
`endif
    if (rst_n) begin
      unique case (r_state)
        ST_FETCH: mem_rden1 = 1'b1;
        ST_EXEC: begin
          case (opcode)
            LW: mem_rden2 = 1'b1;
            SW: begin
              mem_we2  = 1'b1;
              pc_write = mem_ready2;
            end
            LUI, AUIPC, JAL, JALR, OP_IMM, OP_RG3: begin
              pc_write  = 1'b1;
              reg_write = 1'b1;
            end
            BRANCH: pc_write = 1'b1;
            CSR: begin
              pc_write = 1'b1;
              if (func3 == F3_MRET) begin
                mret_exec = 1'b1;
              end else if (func3 == F3_CSRRW) begin
                csr_we    = 1'b1;
                reg_write = 1'b1;
              end
            end
            default: begin
`ifdef CU_ILLEGAL_TRAP_EN
              illegal_instr = 1'b1;
`else
              pc_write = 1'b1;
`endif
            end
          endcase
        end
        ST_WB: begin
          mem_rden2 = 1'b1;
          if (mem_ready2) begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
          end
        end
        ST_INTR: begin
          int_taken = 1'b1;
          pc_write  = 1'b1;
          if (!w_trap_illegal) begin
            irq_ack = w_onehot;
            irq_id  = w_sel;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cu_fsm_irq.sv
// Directed bench for cu_fsm_irq: instruction-level model with per-cycle output compare.
`timescale 1ns/1ps
module tb_cu_fsm_irq;

  localparam int N = 4;

  localparam logic [6:0] O_LUI = 7'b0110111, O_AUIPC = 7'b0010111, O_JAL = 7'b1101111;
  localparam logic [6:0] O_JALR = 7'b1100111, O_BR = 7'b1100011, O_LW = 7'b0000011;
  localparam logic [6:0] O_SW = 7'b0100011, O_IMM = 7'b0010011, O_RG3 = 7'b0110011;
  localparam logic [6:0] O_CSR = 7'b1110011, O_BAD = 7'b1111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] func3 = '0;
  logic mem_ready1 = 1'b0, mem_ready2 = 1'b0, mie = 1'b0;
  logic [N-1:0] irq_in = '0;
  logic pc_write, reg_write, mem_rden1, mem_rden2, mem_we2, csr_we, mret_exec, int_taken;
  logic [N-1:0] irq_ack;
  logic [1:0] irq_id;
`ifdef CU_ILLEGAL_TRAP_EN
  logic illegal_instr;
`endif

  always #5 clk = ~clk;

  cu_fsm_irq #(.NUM_IRQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3),
    .mem_ready1(mem_ready1), .mem_ready2(mem_ready2), .mie(mie), .irq_in(irq_in),
    .pc_write(pc_write), .reg_write(reg_write), .mem_rden1(mem_rden1),
    .mem_rden2(mem_rden2), .mem_we2(mem_we2), .csr_we(csr_we), .mret_exec(mret_exec),
    .int_taken(int_taken), .irq_ack(irq_ack), .irq_id(irq_id)
`ifdef CU_ILLEGAL_TRAP_EN
    , .illegal_instr(illegal_instr)
`endif
  );

  // expected outputs for the current cycle
  logic e_pc, e_rw, e_rd1, e_rd2, e_we2, e_csr, e_mret, e_int, e_ill;
  logic [N-1:0] e_ack;
  logic [1:0] e_id;
  bit exp_valid = 0;

  int n_cmp = 0, n_bad = 0;
  logic [N-1:0] m_pend = '0, m_prev = '0;
  int seen_cnt = 0, seen_id = -1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      chk("pc_write", 32'(pc_write), 32'(e_pc));
      chk("reg_write", 32'(reg_write), 32'(e_rw));
      chk("mem_rden1", 32'(mem_rden1), 32'(e_rd1));
      chk("mem_rden2", 32'(mem_rden2), 32'(e_rd2));
      chk("mem_we2", 32'(mem_we2), 32'(e_we2));
      chk("csr_we", 32'(csr_we), 32'(e_csr));
      chk("mret_exec", 32'(mret_exec), 32'(e_mret));
      chk("int_taken", 32'(int_taken), 32'(e_int));
      chk("irq_ack", 32'(irq_ack), 32'(e_ack));
      chk("irq_id", 32'(irq_id), 32'(e_id));
`ifdef CU_ILLEGAL_TRAP_EN
      chk("illegal_instr", 32'(illegal_instr), 32'(e_ill));
`endif
      if (int_taken === 1'b1) begin
        seen_cnt++;
        seen_id = int'(irq_id);
      end
    end
  end

  task automatic drive(input logic r1, input logic r2, input logic [N-1:0] irq);
    mem_ready1 = r1; mem_ready2 = r2; irq_in = irq;
    e_pc = 0; e_rw = 0; e_rd1 = 0; e_rd2 = 0; e_we2 = 0; e_csr = 0; e_mret = 0;
    e_int = 0; e_ill = 0; e_ack = '0; e_id = '0;
  endtask

  // one clock: compare at negedge, advance the pending model at posedge
  task automatic tick(input logic [N-1:0] ack);
    exp_valid = 1;
    @(negedge clk);
    @(posedge clk);
    if (!rst_n) begin
      m_pend = '0; m_prev = '0;
    end else begin
      m_pend = (m_pend & ~ack) | (irq_in & ~m_prev);
      m_prev = irq_in;
    end
    #1;
  endtask

  task automatic instr(input logic [6:0] opc, input logic [2:0] f3, input int fw, input int mw,
                       input logic [N-1:0] irq_f, input logic [N-1:0] irq_e, input logic [N-1:0] irq_i);
    bit known, go, ill;
    opcode = opc; func3 = f3;
    go = 0; ill = 0;
    known = opc inside {O_LUI, O_AUIPC, O_JAL, O_JALR, O_BR, O_LW, O_SW, O_IMM, O_RG3, O_CSR};
    for (int i = 0; i <= fw; i++) begin
      drive(i == fw, 1'b0, irq_f); e_rd1 = 1; tick('0);
    end
    if (opc == O_LW) begin
      drive(1'b0, 1'b0, irq_e); e_rd2 = 1; tick('0);
      for (int i = 0; i <= mw; i++) begin
        drive(1'b0, i == mw, irq_e); e_rd2 = 1;
        if (i == mw) begin e_rw = 1; e_pc = 1; go = mie && (|m_pend); end
        tick('0);
      end
    end else if (opc == O_SW) begin
      for (int i = 0; i <= mw; i++) begin
        drive(1'b0, i == mw, irq_e); e_we2 = 1;
        if (i == mw) begin e_pc = 1; go = mie && (|m_pend); end
        tick('0);
      end
    end else begin
      drive(1'b0, 1'b0, irq_e);
      go = mie && (|m_pend);
      if (opc == O_BR) e_pc = 1;
      else if (opc == O_CSR) begin
        e_pc = 1;
        if (f3 == 3'b000) begin e_mret = 1; go = 0; end
        else if (f3 == 3'b001) begin e_csr = 1; e_rw = 1; end
      end else if (known) begin
        e_pc = 1; e_rw = 1;
      end else begin
`ifdef CU_ILLEGAL_TRAP_EN
        e_ill = 1; ill = 1; go = 1;
`else
        e_pc = 1;
`endif
      end
      tick('0);
    end
    if (go) begin
      drive(1'b0, 1'b0, irq_i);
      e_int = 1; e_pc = 1;
      if (!ill) begin
        e_id = 2'(lowest(m_pend));
        e_ack[lowest(m_pend)] = 1'b1;
      end
      tick(e_ack);
    end
  endtask

  int c0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset: every output low, including the fetch read
    rst_n = 0;
    drive(1'b1, 1'b1, '0);
    opcode = O_IMM;
    @(posedge clk); #1;
    tick('0); tick('0);
    rst_n = 1;

    // basic two-cycle instructions, fetch wait, loads/stores, CSR variants
    instr(O_IMM, 3'b000, 0, 0, '0, '0, '0);
    instr(O_RG3, 3'b000, 0, 0, '0, '0, '0);
    instr(O_LUI, 3'b000, 2, 0, '0, '0, '0);
    instr(O_AUIPC, 3'b000, 0, 0, '0, '0, '0);
    instr(O_JAL, 3'b000, 1, 0, '0, '0, '0);
    instr(O_JALR, 3'b000, 0, 0, '0, '0, '0);
    instr(O_BR, 3'b000, 0, 0, '0, '0, '0);
    instr(O_LW, 3'b010, 0, 3, '0, '0, '0);
    instr(O_SW, 3'b010, 0, 2, '0, '0, '0);
    instr(O_CSR, 3'b001, 0, 0, '0, '0, '0);
    instr(O_CSR, 3'b010, 0, 0, '0, '0, '0);

    // unknown opcode with mie=0
    c0 = seen_cnt;
    instr(O_BAD, 3'b000, 0, 0, '0, '0, '0);
`ifdef CU_ILLEGAL_TRAP_EN
    chk("illegal_trap_count", 32'(seen_cnt - c0), 32'd1);
    chk("illegal_trap_id", 32'(seen_id), 32'd0);
`else
    chk("unknown_nop_traps", 32'(seen_cnt - c0), 32'd0);
`endif

    // reset in the middle of a load write-back: no strobes
    opcode = O_LW;
    drive(1'b1, 1'b0, '0); e_rd1 = 1; tick('0);
    drive(1'b0, 1'b0, '0); e_rd2 = 1; tick('0);
    rst_n = 0;
    drive(1'b0, 1'b1, '0); tick('0); tick('0);
    rst_n = 1;
    instr(O_IMM, 3'b000, 0, 0, '0, '0, '0);

    // two channels pulsed during an ADD: channel 1 then channel 3
    mie = 1;
    c0 = seen_cnt;
    instr(O_RG3, 3'b000, 0, 0, 4'b1010, 4'b0000, 4'b0000);
    chk("t3_first_id", 32'(seen_id), 32'd1);
    instr(O_IMM, 3'b000, 0, 0, '0, '0, '0);
    chk("t3_second_id", 32'(seen_id), 32'd3);
    instr(O_IMM, 3'b000, 0, 0, '0, '0, '0);
    chk("t3_trap_count", 32'(seen_cnt - c0), 32'd2);

    // mie=0 holds a pending channel across five instructions
    mie = 0;
    c0 = seen_cnt;
    instr(O_IMM, 3'b000, 0, 0, 4'b0001, 4'b0000, '0);
    for (int k = 0; k < 4; k++) instr(O_RG3, 3'b000, 0, 0, '0, '0, '0);
    chk("t4_held_no_trap", 32'(seen_cnt - c0), 32'd0);
    mie = 1;
    instr(O_IMM, 3'b000, 0, 0, '0, '0, '0);
    chk("t4_trap_count", 32'(seen_cnt - c0), 32'd1);
    chk("t4_id", 32'(seen_id), 32'd0);

    // new edge on channel 2 coincident with its own acknowledge
    c0 = seen_cnt;
    instr(O_IMM, 3'b000, 0, 0, 4'b0100, 4'b0000, 4'b0100);
    chk("t5_first_id", 32'(seen_id), 32'd2);
    instr(O_IMM, 3'b000, 0, 0, '0, '0, '0);
    chk("t5_second_id", 32'(seen_id), 32'd2);
    chk("t5_trap_count", 32'(seen_cnt - c0), 32'd2);

    // MRET never enters a trap directly
    c0 = seen_cnt;
    instr(O_CSR, 3'b000, 0, 0, 4'b0001, 4'b0000, '0);
    chk("mret_no_trap", 32'(seen_cnt - c0), 32'd0);
    instr(O_BR, 3'b000, 0, 0, '0, '0, '0);
    chk("after_mret_id", 32'(seen_id), 32'd0);

    // interrupt arriving during a wait-stated load is taken only at write-back exit
    c0 = seen_cnt;
    instr(O_LW, 3'b010, 1, 2, '0, 4'b1000, '0);
    chk("lw_trap_count", 32'(seen_cnt - c0), 32'd1);
    chk("lw_trap_id", 32'(seen_id), 32'd3);
    instr(O_SW, 3'b010, 0, 1, '0, '0, '0);

    exp_valid = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
